// File: rtl/audio_dac_pkg.sv
// audio_dac_pkg: shared state encoding and mode constants for the audio DAC transmitter.
// No ports; imported by audio_dac_tx.
package audio_dac_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LEFT = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;
  localparam int MODE_LJ = 0;
  localparam int MODE_I2S = 1;
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: stereo frame FIFO with wrapped pointers plus an extra bit for full/empty.
// Ports: clk, rst (async active-low), push/din (write), pop/dout (read, dout shows head),
// full, empty, level (frames stored).
module audio_sample_fifo #(
  parameter int width = 32,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [width-1:0]         din,
  input  logic                     pop,
  output logic [width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   level
);
  localparam int AW = $clog2(depth);
  logic [AW:0] wp, rp;
  logic [width-1:0] mem [depth];
  assign level = wp - rp;
  assign empty = wp == rp;
  // level can only reach depth (a power of two) when its top bit is set
  assign full = level[AW];
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/audio_dac_tx.sv
// audio_dac_tx: buffered stereo serializer for an I2S / left-justified audio DAC.
// Ports: AUD_BCLK (bit clock), rst (async active-low), AUD_DACLRCK (1 = left channel),
// wr_valid/wr_left/wr_right/wr_ready (frame producer), AUD_DACDAT (serial data, MSB first),
// frame_done (pulse after right LSB), underrun (pulse when a frame starts on an empty FIFO),
// fifo_level (frames stored).
module audio_dac_tx
  import audio_dac_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int I2S_MODE = 1
) (
  input  logic                          AUD_BCLK,
  input  logic                          rst,
  input  logic                          AUD_DACLRCK,
  input  logic                          wr_valid,
  input  logic [SAMPLE_W-1:0]           wr_left,
  input  logic [SAMPLE_W-1:0]           wr_right,
  output logic                          wr_ready,
  output logic                          AUD_DACDAT,
  output logic                          frame_done,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CW = $clog2(SAMPLE_W + 2);
  localparam logic [CW-1:0] W_C = CW'(SAMPLE_W);
  localparam bit I2S = I2S_MODE == MODE_I2S;
  logic lrck_q, rise, fall, start, full, empty;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [SAMPLE_W-1:0] sh, right_sr, word;
  logic [2*SAMPLE_W-1:0] rd_data;
  assign rise = AUD_DACLRCK & ~lrck_q;
  assign fall = ~AUD_DACLRCK & lrck_q;
  assign start = rise | (fall & state == LEFT);
  assign wr_ready = ~full;
  // a rise starts a new frame (zeros on underrun); a fall switches to the held right word
  assign word = rise ? (empty ? '0 : rd_data[2*SAMPLE_W-1:SAMPLE_W]) : right_sr;
  audio_sample_fifo #(.width(2 * SAMPLE_W), .depth(FIFO_DEPTH)) u_fifo (
    .clk(AUD_BCLK),
    .rst(rst),
    .push(wr_valid & ~full),
    .din({wr_left, wr_right}),
    .pop(rise),
    .dout(rd_data),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  // cnt counts bits driven in the current channel; it parks at SAMPLE_W+1 so frame_done fires once
  always_ff @(posedge AUD_BCLK or negedge rst)
    if (!rst) begin
      state <= IDLE;
      lrck_q <= 1'b0;
      sh <= '0;
      right_sr <= '0;
      cnt <= '0;
      AUD_DACDAT <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      lrck_q <= AUD_DACLRCK;
      underrun <= rise & empty;
      frame_done <= state == RIGHT && cnt == W_C;
      if (rise) begin
        state <= LEFT;
        right_sr <= empty ? '0 : rd_data[SAMPLE_W-1:0];
      end else if (fall && state == LEFT) state <= RIGHT;
      if (start) begin
        AUD_DACDAT <= I2S ? 1'b0 : word[SAMPLE_W-1];
        sh <= I2S ? word : {word[SAMPLE_W-2:0], 1'b0};
        cnt <= I2S ? '0 : CW'(1);
      end else if (state != IDLE && cnt < W_C) begin
        AUD_DACDAT <= sh[SAMPLE_W-1];
        sh <= {sh[SAMPLE_W-2:0], 1'b0};
        cnt <= cnt + 1'b1;
      end else begin
        AUD_DACDAT <= 1'b0;
        if (state != IDLE && cnt == W_C) cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx: three DUT variants (16-bit LJ, 16-bit I2S, 24-bit LJ) checked against a frame-level model.
module tb_audio_dac_tx;
  logic clk = 1'b0, rst = 1'b0, lrck = 1'b0, wv = 1'b0;
  logic [23:0] wl = '0, wr = '0;
  logic [2:0] dat, fd, ur, rdy;
  logic [2:0][2:0] lvl;
  int compared = 0, mismatched = 0;
  int sw[3] = '{16, 16, 24};
  int md[3] = '{0, 1, 0};
  int ch[3], n[3], cnt[3], hd[3];
  logic mq[3], e_dat[3], e_fd[3], e_ur[3];
  logic [23:0] cur[3], rw[3];
  logic [47:0] mem[3][4];
  always #5 clk = ~clk;
  audio_dac_tx #(.SAMPLE_W(16), .FIFO_DEPTH(4), .I2S_MODE(0)) dut_lj (
    .AUD_BCLK(clk), .rst(rst), .AUD_DACLRCK(lrck), .wr_valid(wv), .wr_left(wl[23:8]), .wr_right(wr[23:8]),
    .wr_ready(rdy[0]), .AUD_DACDAT(dat[0]), .frame_done(fd[0]), .underrun(ur[0]), .fifo_level(lvl[0]));
  audio_dac_tx #(.SAMPLE_W(16), .FIFO_DEPTH(4), .I2S_MODE(1)) dut_i2s (
    .AUD_BCLK(clk), .rst(rst), .AUD_DACLRCK(lrck), .wr_valid(wv), .wr_left(wl[23:8]), .wr_right(wr[23:8]),
    .wr_ready(rdy[1]), .AUD_DACDAT(dat[1]), .frame_done(fd[1]), .underrun(ur[1]), .fifo_level(lvl[1]));
  audio_dac_tx #(.SAMPLE_W(24), .FIFO_DEPTH(4), .I2S_MODE(0)) dut_24 (
    .AUD_BCLK(clk), .rst(rst), .AUD_DACLRCK(lrck), .wr_valid(wv), .wr_left(wl), .wr_right(wr),
    .wr_ready(rdy[2]), .AUD_DACDAT(dat[2]), .frame_done(fd[2]), .underrun(ur[2]), .fifo_level(lvl[2]));
  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, i, act, req);
    end
  endtask
  // n = cycles since the current channel started; the bit on the wire is chosen by index, not by shifting
  task automatic model_step(input int i);
    logic rise, fall;
    logic [47:0] f;
    int was, pos;
    if (!rst) begin
      ch[i] = 0; n[i] = 0; cnt[i] = 0; hd[i] = 0; mq[i] = 1'b0;
      cur[i] = '0; rw[i] = '0; e_dat[i] = 1'b0; e_fd[i] = 1'b0; e_ur[i] = 1'b0;
    end else begin
      rise = lrck & ~mq[i];
      fall = ~lrck & mq[i];
      mq[i] = lrck;
      e_fd[i] = ch[i] == 2 && n[i] == sw[i] - 1 + md[i];
      e_ur[i] = 1'b0;
      was = cnt[i];
      if (rise) begin
        if (was == 0) begin
          e_ur[i] = 1'b1; cur[i] = '0; rw[i] = '0;
        end else begin
          f = mem[i][hd[i]]; cur[i] = f[47:24]; rw[i] = f[23:0];
          hd[i] = (hd[i] + 1) % 4; cnt[i]--;
        end
        ch[i] = 1; n[i] = 0;
      end else if (fall && ch[i] == 1) begin
        ch[i] = 2; n[i] = 0; cur[i] = rw[i];
      end else if (ch[i] != 0 && n[i] < 1000) n[i]++;
      if (wv && was < 4) begin
        mem[i][(hd[i] + cnt[i]) % 4] = sw[i] == 16 ? {8'h0, wl[23:8], 8'h0, wr[23:8]} : {wl, wr};
        cnt[i]++;
      end
      pos = n[i] - md[i];
      e_dat[i] = (ch[i] != 0 && pos >= 0 && pos < sw[i]) ? cur[i][sw[i]-1-pos] : 1'b0;
    end
  endtask
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("dacdat", i, 64'(dat[i]), 64'(e_dat[i]));
      chk("frame_done", i, 64'(fd[i]), 64'(e_fd[i]));
      chk("underrun", i, 64'(ur[i]), 64'(e_ur[i]));
      chk("wr_ready", i, 64'(rdy[i]), 64'(cnt[i] < 4));
      chk("fifo_level", i, 64'(lvl[i]), 64'(cnt[i]));
    end
  end
  task automatic tick(input logic lr);
    @(negedge clk);
    lrck = lr;
    @(posedge clk);
    #2;
  endtask
  task automatic push1(input logic [23:0] l, input logic [23:0] r);
    @(negedge clk);
    wv = 1'b1; wl = l; wr = r;
  endtask
  task automatic stop_push();
    @(negedge clk);
    wv = 1'b0;
  endtask
  initial begin
    logic [63:0] c0, c1;
    logic [31:0] c2;
    int nfd, urc, any;
    repeat (3) @(negedge clk);
    chk("reset_dacdat", 0, 64'(dat[0]), 64'd0);
    chk("reset_ready", 0, 64'(rdy[0]), 64'd1);
    chk("reset_level", 0, 64'(lvl[0]), 64'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) tick(1'b0);
    push1(24'hA5C300, 24'h0F0F00);
    stop_push();
    c0 = '0; c1 = '0; nfd = 0;
    for (int j = 0; j < 64; j++) begin
      tick(j < 32);
      c0 = {c0[62:0], dat[0]};
      c1 = {c1[62:0], dat[1]};
      nfd += int'(fd[0]);
    end
    chk("lj_bits", 0, c0, {16'hA5C3, 16'h0, 16'h0F0F, 16'h0});
    chk("i2s_bits", 1, c1, {1'b0, 16'hA5C3, 15'h0, 1'b0, 16'h0F0F, 15'h0});
    chk("frame_done_count", 0, 64'(nfd), 64'd1);
    c0 = '0; urc = 0;
    for (int j = 0; j < 64; j++) begin
      tick(j < 32);
      c0 = {c0[62:0], dat[0]};
      urc += int'(ur[0]);
    end
    chk("underrun_zero_bits", 0, c0, 64'd0);
    chk("underrun_count", 0, 64'(urc), 64'd1);
    chk("underrun_level", 0, 64'(lvl[0]), 64'd0);
    for (int j = 0; j < 5; j++) push1(24'h123456 + 24'(j), ~(24'h123456 + 24'(j)));
    stop_push();
    chk("full_level", 0, 64'(lvl[0]), 64'd4);
    chk("full_ready", 0, 64'(rdy[0]), 64'd0);
    c2 = '0; nfd = 0;
    for (int j = 0; j < 64; j++) begin
      tick((j % 32) < 16);
      if (j < 32) c2 = {c2[30:0], dat[2]};
      nfd += int'(fd[2]);
    end
    chk("trunc_bits", 2, 64'(c2), 64'h1234EDCB);
    chk("trunc_no_frame_done", 2, 64'(nfd), 64'd0);
    push1(24'h0FACE0, 24'h0BEEF0);
    push1(24'h0C0DE0, 24'h0D00D0);
    stop_push();
    repeat (7) tick(1'b1);
    chk("pre_reset_level", 0, 64'(lvl[0]), 64'd3);
    @(negedge clk);
    rst = 1'b0;
    lrck = 1'b0;
    #1;
    chk("mid_reset_dacdat", 0, 64'(dat[0]), 64'd0);
    chk("mid_reset_level", 0, 64'(lvl[0]), 64'd0);
    chk("mid_reset_ready", 0, 64'(rdy[0]), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    any = 0;
    for (int j = 0; j < 8; j++) begin
      tick(1'b0);
      any += int'(dat[0]) + int'(dat[1]) + int'(dat[2]) + int'(ur[0]);
    end
    chk("post_reset_idle", 0, 64'(any), 64'd0);
    tick(1'b1);
    chk("post_reset_underrun", 0, 64'(ur[0]), 64'd1);
    repeat (4) tick(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
